karatsuba_pipe: RTL and testbench

KARATSUBA_PIPE -- requirements
Module: karatsuba_pipe

---
 rtl/karatsuba_pkg.sv | 18 +
 rtl/karatsuba_sub.sv | 14 +
 rtl/karatsuba_pipe.sv | 133 +++++++++++++
 tb/tb_karatsuba_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared constants and width helpers for the three-stage Karatsuba multiplier.
package karatsuba_pkg;

  localparam int unsigned STAGES = 3;

  function automatic int unsigned half_w(input int unsigned n);
    return n / 2;
  endfunction

  function automatic int unsigned sum_w(input int unsigned n);
    return (n / 2) + 1;
  endfunction

  function automatic int unsigned mid_w(input int unsigned n);
    return n + 2;
  endfunction

endpackage

// File: rtl/karatsuba_sub.sv
// Combinational unsigned W x W multiplier used for each Karatsuba sub-product.
module karatsuba_sub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p_c
);

  localparam int unsigned PW = 2 * W;

  assign p_c = PW'(a) * PW'(b);

endmodule

// File: rtl/karatsuba_pipe.sv
// Three-stage Karatsuba multiplier (split, sub-products, combine) with a
// valid/ready handshake; the whole pipe freezes while the output is stalled.
module karatsuba_pipe
  import karatsuba_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Z
);

  localparam int unsigned HALF = half_w(N);
  localparam int unsigned SUMW = sum_w(N);
  localparam int unsigned MIDW = mid_w(N);
  localparam int unsigned ZW   = 2 * N;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [HALF-1:0] xh1_q, xh1_d, xl1_q, xl1_d, yh1_q, yh1_d, yl1_q, yl1_d;
  logic [SUMW-1:0] xs1_q, xs1_d, ys1_q, ys1_d;
  logic            sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [MIDW-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [ZW-1:0]   z_q, z_d;

  logic            adv, take;
  logic [N-1:0]    xm, ym;
  logic [MIDW-1:0] p0_c, p1_c, p2_c, mid;
  logic [ZW-1:0]   sum;

  // The pipe advances unless a finished product is waiting on the consumer.
  assign adv       = !v3_q || out_ready;
  assign in_ready  = !rst && adv;
  assign take      = in_valid && in_ready;
  assign out_valid = v3_q;
  assign Z         = z_q;

  // Magnitudes: -2^(N-1) negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    xm = X;
    ym = Y;
    if (SIGNED != 0) begin
      if (X[N-1]) xm = -X;
      if (Y[N-1]) ym = -Y;
    end
  end

  karatsuba_sub #(.W(SUMW)) u_p0 (.a(SUMW'(xl1_q)), .b(SUMW'(yl1_q)), .p_c(p0_c));
  karatsuba_sub #(.W(SUMW)) u_p2 (.a(SUMW'(xh1_q)), .b(SUMW'(yh1_q)), .p_c(p2_c));
  karatsuba_sub #(.W(SUMW)) u_p1 (.a(xs1_q),        .b(ys1_q),        .p_c(p1_c));

  // Middle term is non-negative and fits in MIDW bits; widen before shifting.
  always_comb begin
    mid = p1_q - p2_q - p0_q;
    sum = (ZW'(p2_q) << N) + (ZW'(mid) << HALF) + ZW'(p0_q);
  end

  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    xh1_d  = xh1_q;
    xl1_d  = xl1_q;
    yh1_d  = yh1_q;
    yl1_d  = yl1_q;
    xs1_d  = xs1_q;
    ys1_d  = ys1_q;
    sgn1_d = sgn1_q;
    sgn2_d = sgn2_q;
    p0_d   = p0_q;
    p1_d   = p1_q;
    p2_d   = p2_q;
    z_d    = z_q;
    if (adv) begin
      v1_d = take;
      v2_d = v1_q;
      v3_d = v2_q;
      if (take) begin
        xh1_d  = xm[N-1:HALF];
        xl1_d  = xm[HALF-1:0];
        yh1_d  = ym[N-1:HALF];
        yl1_d  = ym[HALF-1:0];
        xs1_d  = SUMW'(xm[N-1:HALF]) + SUMW'(xm[HALF-1:0]);
        ys1_d  = SUMW'(ym[N-1:HALF]) + SUMW'(ym[HALF-1:0]);
        sgn1_d = (SIGNED != 0) && (X[N-1] ^ Y[N-1]);
      end
      if (v1_q) begin
        p0_d   = p0_c;
        p1_d   = p1_c;
        p2_d   = p2_c;
        sgn2_d = sgn1_q;
      end
      // Bubbles leave Z untouched so it always shows the last real product.
      if (v2_q) z_d = sgn2_q ? -sum : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      z_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      z_q  <= z_d;
    end
  end

  // Datapath stage registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    xh1_q  <= xh1_d;
    xl1_q  <= xl1_d;
    yh1_q  <= yh1_d;
    yl1_q  <= yl1_d;
    xs1_q  <= xs1_d;
    ys1_q  <= ys1_d;
    sgn1_q <= sgn1_d;
    sgn2_q <= sgn2_d;
    p0_q   <= p0_d;
    p1_q   <= p1_d;
    p2_q   <= p2_d;
  end

endmodule

// File: tb/tb_karatsuba_pipe.sv
// Directed and random checks of karatsuba_pipe in four configurations against
// a plain X*Y reference model held in per-instance scoreboards.
module tb_karatsuba_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv[4], ordy[4], irdy[4], ov[4];
  logic [63:0] xx[4], yy[4], zz[4];
  logic [31:0] z0, z1;
  logic [15:0] z2;
  logic [63:0] z3;

  int total = 0;
  int bad   = 0;
  int acc[4];
  logic [63:0] q0[$], q1[$], q2[$], q3[$];

  localparam int NW[4] = '{16, 16, 8, 32};
  localparam bit SG[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  karatsuba_pipe #(.N(16), .SIGNED(0)) d0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .X(xx[0][15:0]), .Y(yy[0][15:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .Z(z0));
  karatsuba_pipe #(.N(16), .SIGNED(1)) d1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .X(xx[1][15:0]), .Y(yy[1][15:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .Z(z1));
  karatsuba_pipe #(.N(8), .SIGNED(0)) d2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .X(xx[2][7:0]), .Y(yy[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .Z(z2));
  karatsuba_pipe #(.N(32), .SIGNED(0)) d3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .X(xx[3][31:0]), .Y(yy[3][31:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .Z(z3));

  assign zz[0] = 64'(z0);
  assign zz[1] = 64'(z1);
  assign zz[2] = 64'(z2);
  assign zz[3] = z3;

  function automatic logic [63:0] mask_w(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_mul(input int n, input bit sg, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    if (sg) begin
      sa = $signed(a << (64 - n)) >>> (64 - n);
      sb = $signed(b << (64 - n)) >>> (64 - n);
      p  = sa * sb;
    end else begin
      p = a * b;
    end
    return p & mask_w(2 * n);
  endfunction

  function automatic logic [63:0] pick(input int n);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask_w(n);
      2:       return 64'd1 << (n - 1);
      default: return {$urandom, $urandom} & mask_w(n);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [63:0] v);
    acc[i]++;
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic pop_chk(input int i);
    logic [63:0] e;
    if (sb_size(i) == 0) begin
      chk($sformatf("out_valid_with_empty_sb%0d", i), 64'(ov[i]), 64'd0);
    end else begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      chk($sformatf("z_dut%0d", i), zz[i], e);
    end
  endtask

  task automatic clear_sb();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  // Evaluate this cycle's transfers against the scoreboard, then advance one clock.
  task automatic step();
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ov[i] && ordy[i]) pop_chk(i);
      if (iv[i] && irdy[i]) push_exp(i, ref_mul(NW[i], SG[i], xx[i], yy[i]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic [63:0] x, input logic [63:0] y);
    iv[i] = 1'b1;
    xx[i] = x;
    yy[i] = y;
  endtask

  initial begin
    logic [63:0] e0, rx, ry;
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; xx[i] = '0; yy[i] = '0; acc[i] = 0;
    end
    @(posedge clk); #1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_out_valid%0d", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_z%0d", i), zz[i], 64'd0);
      chk($sformatf("rst_in_ready%0d", i), 64'(irdy[i]), 64'd0);
    end
    clear_sb();
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(irdy[0]), 64'd1);

    // Max unsigned operands and exact 3-cycle latency
    drv(0, 64'hFFFF, 64'hFFFF); step(); iv[0] = 1'b0;
    chk("lat_c1", 64'(ov[0]), 64'd0); step();
    chk("lat_c2", 64'(ov[0]), 64'd0); step();
    chk("lat_c3", 64'(ov[0]), 64'd1);
    chk("max_product", zz[0], 64'hFFFE0001);
    step();

    // Back-to-back products on consecutive cycles
    drv(0, 64'h1234, 64'h5678); step();
    drv(0, 64'h0, 64'hABCD); step(); iv[0] = 1'b0;
    step();
    chk("b2b_first", zz[0], 64'h06260060);
    chk("b2b_first_v", 64'(ov[0]), 64'd1); step();
    chk("b2b_second", zz[0], 64'h0);
    chk("b2b_second_v", 64'(ov[0]), 64'd1); step();
    chk("b2b_drained", 64'(ov[0]), 64'd0);

    // Signed corners
    drv(1, 64'h8000, 64'h8000); step();
    drv(1, 64'hFFFF, 64'h0002); step(); iv[1] = 1'b0;
    step();
    chk("signed_minmin", zz[1], 64'h40000000); step();
    chk("signed_neg", zz[1], 64'hFFFFFFFE); step();

    // Stall with five products: hold out_ready low for 4 cycles after first output
    e0 = 64'h0;
    for (int k = 0; k < 3; k++) begin
      rx = pick(16); ry = pick(16);
      if (k == 0) e0 = ref_mul(16, 1'b0, rx, ry);
      drv(0, rx, ry); step();
    end
    chk("stall_first_ov", 64'(ov[0]), 64'd1);
    ordy[0] = 1'b0;
    drv(0, 64'hDEAD, 64'hBEEF);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_in_ready", 64'(irdy[0]), 64'd0);
      chk("stall_z_hold", zz[0], e0);
      chk("stall_ov_hold", 64'(ov[0]), 64'd1);
      step();
    end
    ordy[0] = 1'b1;
    drv(0, pick(16), pick(16)); step();
    drv(0, pick(16), pick(16)); step();
    iv[0] = 1'b0;
    repeat (6) step();
    chk("stall_all_out", 64'(q0.size()), 64'd0);
    chk("stall_count", 64'(acc[0]), 64'd8);

    // Reset with two products in flight
    drv(0, 64'h0011, 64'h0022); step();
    drv(0, 64'h0033, 64'h0044); step();
    iv[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(irdy[0]), 64'd0);
    step();
    clear_sb();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_quiet", 64'(ov[0]), 64'd0);
      step();
    end
    drv(0, 64'd3, 64'd5); step(); iv[0] = 1'b0;
    chk("post_rst_c1", 64'(ov[0]), 64'd0); step();
    chk("post_rst_c2", 64'(ov[0]), 64'd0); step();
    chk("post_rst_c3", 64'(ov[0]), 64'd1);
    chk("post_rst_z", zz[0], 64'd15);
    step();

    // Random traffic on all instances until N=8 and N=32 each took 10000 operands
    for (int i = 0; i < 4; i++) acc[i] = 0;
    cyc = 0;
    while ((acc[2] < 10000 || acc[3] < 10000) && cyc < 60000) begin
      for (int i = 0; i < 4; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 3) != 0);
        xx[i]   = pick(NW[i]);
        yy[i]   = pick(NW[i]);
      end
      step();
      cyc++;
    end
    chk("rand_n8_count", 64'(acc[2] >= 10000), 64'd1);
    chk("rand_n32_count", 64'(acc[3] >= 10000), 64'd1);
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (6) step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand_drain%0d", i), 64'(sb_size(i)), 64'd0);
      chk($sformatf("rand_idle%0d", i), 64'(ov[i]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
